// File: rtl/decoder_scan_if.sv
// Select/output bundle for decoder_scan.
//   master: drives en, mode, sel_valid, sel, dwell; observes sel_ready, f, idx,
//           out_valid, wrap, err.
//   slave : the decoder side of the same signals.
interface decoder_scan_if #(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned DWELL_W = 8
);
  logic               en;
  logic               mode;
  logic               sel_valid;
  logic               sel_ready;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   f;
  logic [SEL_W-1:0]   idx;
  logic               out_valid;
  logic               wrap;
  logic               err;

  modport master (
    output en, mode, sel_valid, sel, dwell,
    input  sel_ready, f, idx, out_valid, wrap, err
  );

  modport slave (
    input  en, mode, sel_valid, sel, dwell,
    output sel_ready, f, idx, out_valid, wrap, err
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with select handshake and an
// autonomous scan mode that walks the active line with a programmable dwell.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - decoder_scan_if.slave: en, mode, sel_valid/sel_ready, sel, dwell in;
//          f (one-hot lines), idx, out_valid, wrap, err out (all registered
//          except sel_ready, which is combinational)
// Optional build macro DECODER_SCAN_ACTIVE_LOW_EN: f is driven active-low
// (idle/err value all-ones, active line a single 0); other outputs unchanged.
module decoder_scan #(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned OUT_W   = 16,  // legal range 2..2**SEL_W
  parameter int unsigned DWELL_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  decoder_scan_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

  localparam int unsigned CMP_W = SEL_W + 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] F_OFF = '1;
`else
  localparam logic [OUT_W-1:0] F_OFF = '0;
`endif

  // Physical line pattern for an in-range index.
  function automatic logic [OUT_W-1:0] line(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] oh;
    oh = OUT_W'(1) << i;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    return ~oh;
`else
    return oh;
`endif
  endfunction

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   f_q, f_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               ov_q, ov_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic sel_ready_c;
  logic accept_c;
  logic sel_oob_c;
  logic [SEL_W-1:0] idx_nxt_c;

  assign sel_ready_c = bus.en & ~bus.mode & ~rst;
  assign accept_c    = bus.sel_valid & sel_ready_c;
  // Extra bit so OUT_W == 2**SEL_W is representable.
  assign sel_oob_c   = {1'b0, bus.sel} >= CMP_W'(OUT_W);
  assign idx_nxt_c   = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      f_q     <= F_OFF;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

  // Next state and next output values; en outranks mode, mode outranks sel.
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    idx_d   = idx_q;
    ov_d    = ov_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;

    if (!bus.en) begin
      state_d = IDLE;
      f_d     = F_OFF;
      idx_d   = '0;
      ov_d    = 1'b0;
      cnt_d   = '0;
    end else if (!bus.mode) begin
      state_d = DECODE;
      cnt_d   = '0;
      if (accept_c) begin
        idx_d = bus.sel;
        ov_d  = 1'b1;
        if (sel_oob_c) begin
          f_d   = F_OFF;
          err_d = 1'b1;
        end else begin
          f_d = line(bus.sel);
        end
      end else if (state_q != DECODE) begin
        // Freshly entered decode: blank until the first accept.
        f_d   = F_OFF;
        idx_d = '0;
        ov_d  = 1'b0;
      end
    end else begin
      state_d = SCAN;
      ov_d    = 1'b1;
      if (state_q != SCAN) begin
        // Scan always restarts at line 0; no wrap on entry.
        idx_d   = '0;
        f_d     = line('0);
        cnt_d   = '0;
        dwell_d = bus.dwell;
      end else if (cnt_q == dwell_q) begin
        // Line done: advance and latch the dwell for the new line.
        idx_d   = idx_nxt_c;
        f_d     = line(idx_nxt_c);
        wrap_d  = (idx_q == LAST_IDX);
        cnt_d   = '0;
        dwell_d = bus.dwell;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  assign bus.sel_ready = sel_ready_c;
  assign bus.f         = f_q;
  assign bus.idx       = idx_q;
  assign bus.out_valid = ov_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: a 16-line and a 10-line instance share one set of
// directed stimulus; a behavioural model predicts every output each cycle.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       sel_valid = 1'b0;
  logic [3:0] sel = 4'd0;
  logic [7:0] dwell = 8'd0;
  bit         checking = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(4), .OUT_W(16), .DWELL_W(8)) b16 ();
  decoder_scan_if #(.SEL_W(4), .OUT_W(10), .DWELL_W(8)) b10 ();

  assign b16.en = en;  assign b16.mode = mode;  assign b16.sel_valid = sel_valid;
  assign b16.sel = sel; assign b16.dwell = dwell;
  assign b10.en = en;  assign b10.mode = mode;  assign b10.sel_valid = sel_valid;
  assign b10.sel = sel; assign b10.dwell = dwell;

  decoder_scan #(.SEL_W(4), .OUT_W(16), .DWELL_W(8)) u16 (.clk(clk), .rst(rst), .bus(b16));
  decoder_scan #(.SEL_W(4), .OUT_W(10), .DWELL_W(8)) u10 (.clk(clk), .rst(rst), .bus(b10));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Active-high line pattern to physical pin value.
  function automatic logic [15:0] pin(input logic [15:0] v);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Model: phase 0 idle, 1 decode, 2 scan; hold = cycles left on current line.
  int       ph   [2];
  bit [15:0] mf  [2];
  int       midx [2];
  bit       mov  [2];
  bit       mwrap[2];
  bit       merr [2];
  int       hold [2];

  task automatic model_step(input int k);
    int ow;
    ow = (k == 0) ? 16 : 10;
    mwrap[k] = 1'b0;
    merr[k]  = 1'b0;
    if (!en) begin
      ph[k] = 0; mf[k] = '0; midx[k] = 0; mov[k] = 1'b0;
    end else if (!mode) begin
      if (sel_valid) begin
        midx[k] = int'(sel);
        mov[k]  = 1'b1;
        if (int'(sel) >= ow) begin mf[k] = '0; merr[k] = 1'b1; end
        else mf[k] = 16'(1) << sel;
      end else if (ph[k] != 1) begin
        mf[k] = '0; mov[k] = 1'b0; midx[k] = 0;
      end
      ph[k] = 1;
    end else begin
      if (ph[k] != 2) begin
        midx[k] = 0;
        hold[k] = int'(dwell) + 1;
      end else begin
        hold[k] = hold[k] - 1;
        if (hold[k] == 0) begin
          if (midx[k] == ow - 1) begin midx[k] = 0; mwrap[k] = 1'b1; end
          else midx[k] = midx[k] + 1;
          hold[k] = int'(dwell) + 1;
        end
      end
      mf[k]  = 16'(1) << midx[k];
      mov[k] = 1'b1;
      ph[k]  = 2;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        ph[k] = 0; mf[k] = '0; midx[k] = 0; mov[k] = 1'b0;
        mwrap[k] = 1'b0; merr[k] = 1'b0; hold[k] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  function automatic logic [31:0] phys(input int k);
    logic [31:0] m;
    m = (k == 0) ? 32'hFFFF : 32'h03FF;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    return ~{16'h0, mf[k]} & m;
`else
    return {16'h0, mf[k]} & m;
`endif
  endfunction

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("ready16", 32'(b16.sel_ready), 32'(en & ~mode & ~rst));
      chk("f16",     32'(b16.f),         phys(0));
      chk("idx16",   32'(b16.idx),       32'(midx[0]));
      chk("ov16",    32'(b16.out_valid), 32'(mov[0]));
      chk("wrap16",  32'(b16.wrap),      32'(mwrap[0]));
      chk("err16",   32'(b16.err),       32'(merr[0]));
      chk("ready10", 32'(b10.sel_ready), 32'(en & ~mode & ~rst));
      chk("f10",     32'(b10.f),         phys(1));
      chk("idx10",   32'(b10.idx),       32'(midx[1]));
      chk("ov10",    32'(b10.out_valid), 32'(mov[1]));
      chk("wrap10",  32'(b10.wrap),      32'(mwrap[1]));
      chk("err10",   32'(b10.err),       32'(merr[1]));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] off10;

  initial begin
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    off10 = 32'h3FF;
`else
    off10 = 32'h0;
`endif
    checking = 1'b1;
    tick(2);
    chk("lit_rst_f",   32'(b16.f), 32'(pin(16'h0000)));
    chk("lit_rst_idx", 32'(b16.idx), 32'd0);
    chk("lit_rst_ov",  32'(b16.out_valid), 32'd0);
    rst = 1'b0;
    tick(1);

    // Back-to-back decode accepts.
    en = 1'b1; mode = 1'b0; sel_valid = 1'b1; sel = 4'd5;
    tick(1); chk("lit_dec5",  32'(b16.f), 32'(pin(16'h0020)));
             chk("lit_dec_ov", 32'(b16.out_valid), 32'd1);
    sel = 4'd0;
    tick(1); chk("lit_dec0",  32'(b16.f), 32'(pin(16'h0001)));
    sel = 4'd15;
    tick(1); chk("lit_dec15", 32'(b16.f), 32'(pin(16'h8000)));
             chk("lit_dec15_err10", 32'(b10.err), 32'd1);
    sel = 4'd3;
    tick(1); chk("lit_dec3",  32'(b16.f), 32'(pin(16'h0008)));
    sel_valid = 1'b0; sel = 4'd9;
    tick(2); chk("lit_hold",  32'(b16.f), 32'(pin(16'h0008)));

    // Out-of-range select on the 10-line instance.
    sel_valid = 1'b1; sel = 4'd12;
    tick(1); chk("lit10_err",   32'(b10.err), 32'd1);
             chk("lit10_err_f", 32'(b10.f), off10);
             chk("lit10_err_ov", 32'(b10.out_valid), 32'd1);
             chk("lit10_err_idx", 32'(b10.idx), 32'd12);
    sel_valid = 1'b0;
    tick(1); chk("lit10_err_pulse", 32'(b10.err), 32'd0);

    // Scan with dwell 2, sel_valid ignored.
    mode = 1'b1; dwell = 8'd2; sel_valid = 1'b1; sel = 4'd7;
    #1 chk("lit_scan_ready", 32'(b16.sel_ready), 32'd0);
    tick(1); chk("lit_scan_entry", 32'(b16.f), 32'(pin(16'h0001)));
             chk("lit_scan_nowrap", 32'(b16.wrap), 32'd0);
    for (int t = 1; t <= 48; t++) begin
      tick(1);
      if (t == 27) chk("lit10_idx9", 32'(b10.idx), 32'd9);
      if (t == 30) begin
        chk("lit10_wrap", 32'(b10.wrap), 32'd1);
        chk("lit10_wrap_idx", 32'(b10.idx), 32'd0);
      end
      if (t == 47) chk("lit_scan_last", 32'(b16.f), 32'(pin(16'h8000)));
      if (t == 48) begin
        chk("lit_scan_wrap_f", 32'(b16.f), 32'(pin(16'h0001)));
        chk("lit_scan_wrap",   32'(b16.wrap), 32'd1);
      end
    end
    tick(1); chk("lit_wrap_pulse", 32'(b16.wrap), 32'd0);

    // Dwell change mid-line applies from the next line.
    dwell = 8'd0;
    tick(1); chk("lit_dw_hold", 32'(b16.f), 32'(pin(16'h0001)));
    tick(1); chk("lit_dw_l1",   32'(b16.f), 32'(pin(16'h0002)));
    tick(1); chk("lit_dw_l2",   32'(b16.f), 32'(pin(16'h0004)));

    // Enable dropped mid-dwell, then re-enabled.
    dwell = 8'd2;
    tick(1); chk("lit_dw_l3", 32'(b16.f), 32'(pin(16'h0008)));
    en = 1'b0;
    tick(1); chk("lit_en_f",  32'(b16.f), 32'(pin(16'h0000)));
             chk("lit_en_ov", 32'(b16.out_valid), 32'd0);
    tick(1);
    en = 1'b1;
    tick(1); chk("lit_reen", 32'(b16.f), 32'(pin(16'h0001)));
             chk("lit_reen_idx", 32'(b16.idx), 32'd0);

    // Scan to decode: blank until first accept.
    mode = 1'b0; sel_valid = 1'b0;
    tick(1); chk("lit_sw_f",  32'(b16.f), 32'(pin(16'h0000)));
             chk("lit_sw_ov", 32'(b16.out_valid), 32'd0);
    tick(1);
    sel_valid = 1'b1; sel = 4'd5;
    tick(1); chk("lit_sw_acc", 32'(b16.f), 32'(pin(16'h0020)));
    sel_valid = 1'b0;

    // sel_valid during scan has no effect.
    mode = 1'b1; dwell = 8'd5;
    tick(1); chk("lit_sv_entry", 32'(b16.f), 32'(pin(16'h0001)));
    sel_valid = 1'b1; sel = 4'd7;
    #1 chk("lit_sv_ready", 32'(b16.sel_ready), 32'd0);
    tick(1); chk("lit_sv_f", 32'(b16.f), 32'(pin(16'h0001)));

    // Asynchronous reset between edges mid-scan.
    tick(2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("lit_arst_f",   32'(b16.f), 32'(pin(16'h0000)));
    chk("lit_arst_ov",  32'(b16.out_valid), 32'd0);
    chk("lit_arst_idx", 32'(b16.idx), 32'd0);
    chk("lit_arst_rdy", 32'(b16.sel_ready), 32'd0);
    tick(1);
    rst = 1'b0; sel_valid = 1'b0;
    tick(1); chk("lit_arst_rel", 32'(b16.f), 32'(pin(16'h0001)));
             chk("lit_arst_rel_ov", 32'(b16.out_valid), 32'd1);
    tick(2);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered binary-to-one-hot decoder. Successor to the fixed 4-to-16 combinational decoders.
- Adds a clocked select handshake and an autonomous scan mode that walks the one-hot output across all lines with a programmable dwell time.
- Drives row/digit-select lines for LED/keypad scanners and bank selects in the VLSI lab designs.

Parameters:
- SEL_W, 4, width of binary select input.
- OUT_W, 16, number of one-hot output lines; legal range 2..2**SEL_W.
- DWELL_W, 8, width of dwell-count input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  block enable; low forces idle.
- mode  input  1  0 = decode, 1 = scan.
- sel_valid  input  1  select word offered.
- sel_ready  output  1  select accepted this cycle when sel_valid also high.
- sel  input  SEL_W  binary select (decode mode).
- dwell  input  DWELL_W  scan hold; each line held dwell+1 cycles.
- f  output  OUT_W  one-hot output, registered.
- idx  output  SEL_W  binary index of active line (0 when none).
- out_valid  output  1  f holds a valid decoded/scanned value.
- wrap  output  1  one-cycle pulse when scan returns from line OUT_W-1 to 0.
- err  output  1  one-cycle pulse when accepted sel >= OUT_W.

Behaviour:
- Reset (async, immediate):
  - f=0, idx=0, out_valid=0, wrap=0, err=0.
  - Dwell counter=0; state=IDLE.
  - sel_ready is combinational; it is 0 while rst is high.
- States: IDLE, DECODE, SCAN. All transitions take place on a clock edge.
- Enable:
  - en=0 from any state -> IDLE next cycle.
  - In IDLE: f=0, out_valid=0, idx=0, counter cleared.
  - en has priority over mode and sel_valid.
- IDLE transitions: en=1 & mode=0 -> DECODE; en=1 & mode=1 -> SCAN.
- DECODE:
  - sel_ready = en & ~mode & ~rst.
  - Accept (sel_valid & sel_ready) at edge N -> at N+1: f = 1<<sel, idx=sel, out_valid=1. One-cycle latency.
  - Back-to-back accepts are allowed every cycle.
  - f holds its value until the next accept.
  - sel >= OUT_W: f=0, idx=sel, out_valid=1, err=1 for one cycle.
  - Entering DECODE from SCAN: f=0, out_valid=0 until the first accept.
- SCAN:
  - sel_ready=0; sel_valid is ignored.
  - On entry, idx=0, f=1, out_valid=1 from the first SCAN cycle.
  - dwell is sampled when a line becomes active; a change mid-dwell takes effect on the next line.
  - Counter counts 0..dwell; at dwell it advances idx = (idx==OUT_W-1) ? 0 : idx+1.
  - wrap=1 in the cycle f returns to line 0, not on initial entry.
  - dwell=0 advances every cycle.
- Mode change while en=1: takes effect next edge per the transitions above; the scan index is not preserved.
- Only one bit of f is ever high. f=0 whenever out_valid=0.

Optional Feature:
- Macro DECODER_SCAN_ACTIVE_LOW_EN.
- Defined: f is driven inverted (active-low lines).
  - Reset/idle value is all-ones.
  - Active line is a single 0; err case gives all-ones.
  - idx, out_valid, wrap and err are unchanged.
- Undefined: active-high f as specified above.

Test Plan:
- Reset: assert rst mid-scan between clock edges -> f=16'h0000, out_valid=0, idx=0 immediately. Release, en=1, mode=1 -> f=16'h0001 next edge.
- Decode: sel 5, 0, 15 accepted on three consecutive edges -> f=16'h0020, 16'h0001, 16'h8000 one cycle after each; out_valid=1 throughout.
- Scan: dwell=2 -> each line held 3 cycles, 16'h0001 through 16'h8000. After 48 cycles f=16'h0001 with wrap=1 for exactly that cycle. Changing dwell to 0 mid-line takes effect on the next line only.
- OUT_W=10 instance:
  - Decode sel=12 -> f=0, err=1 for one cycle, out_valid=1.
  - Scan wraps from idx 9 to idx 0 with wrap=1.
- Enable/mode:
  - en dropped mid-dwell -> f=0, out_valid=0 next edge.
  - Re-enable restarts at idx 0.
  - Switching from scan to decode -> f=0 until the first accept.
  - sel_valid while mode=1 -> sel_ready=0 and no change to f.
- With DECODER_SCAN_ACTIVE_LOW_EN defined: reset f=16'hFFFF; decode sel=3 -> f=16'hFFF7.
